// File: rtl/de_hazard_scoreboard.sv
// Decode-stage register/CSR scoreboard: per-register pending-write counters,
// hazard stall generation to FE and issue qualification into AGEX.
module de_hazard_scoreboard #(
  parameter int REGNOBITS = 5,
  parameter int CSRNOBITS = 4,
  parameter int CNTBITS   = 2,
  parameter int MAX_PEND  = 3,
  parameter int WB_BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      de_valid,
  input  logic [REGNOBITS-1:0]      rs1,
  input  logic                      rs1_used,
  input  logic [REGNOBITS-1:0]      rs2,
  input  logic                      rs2_used,
  input  logic [REGNOBITS-1:0]      rd,
  input  logic                      rd_wr,
  input  logic [CSRNOBITS-1:0]      csr_rs,
  input  logic                      csr_rd_used,
  input  logic                      csr_wr,
  input  logic                      flush,
  input  logic                      wb_wr_reg,
  input  logic [REGNOBITS-1:0]      wb_regno,
  input  logic                      wb_wr_csr,
  input  logic [CSRNOBITS-1:0]      wb_csrno,
  output logic                      stall,
  output logic                      issue,
  output logic [(1<<REGNOBITS)-1:0] busy_vec,
  output logic [(1<<CSRNOBITS)-1:0] csr_busy_vec,
  output logic                      err_underflow,
  output logic [31:0]               stall_cycles
);

  localparam int NREG = 1 << REGNOBITS;
  localparam int NCSR = 1 << CSRNOBITS;
  localparam logic [CNTBITS-1:0] CNT_FULL = CNTBITS'(MAX_PEND);
  localparam logic               BYPASS   = (WB_BYPASS != 0);

  logic [CNTBITS-1:0] r_gpr_cnt [NREG];
  logic [CNTBITS-1:0] r_csr_cnt [NCSR];
  logic [CNTBITS-1:0] w_gpr_eff [NREG];
  logic [CNTBITS-1:0] w_csr_eff [NCSR];

  logic        r_err_underflow;
  logic [31:0] r_stall_cycles;

  logic w_hazard;
  logic w_stall;
  logic w_issue;
  logic w_gpr_uf;
  logic w_csr_uf;

  // GPR counters; x0 never increments and never releases, so it stays at zero.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_gpr
      logic w_rel;
      logic w_inc;
      logic w_dec;

      assign w_rel = wb_wr_reg && (wb_regno == REGNOBITS'(gi)) && (gi != 0);
      assign w_inc = w_issue && rd_wr && (rd == REGNOBITS'(gi)) && (gi != 0);
      assign w_dec = w_rel && (r_gpr_cnt[gi] != '0);

      // A release of an idle register cannot lower the view below zero.
      assign w_gpr_eff[gi] = (BYPASS && w_dec) ? r_gpr_cnt[gi] - 1'b1 : r_gpr_cnt[gi];
      assign busy_vec[gi]  = (r_gpr_cnt[gi] != '0);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_gpr_cnt[gi] <= '0;
        end else if (w_inc && !w_dec) begin
          r_gpr_cnt[gi] <= r_gpr_cnt[gi] + 1'b1;
        end else if (w_dec && !w_inc) begin
          r_gpr_cnt[gi] <= r_gpr_cnt[gi] - 1'b1;
        end
      end
    end

    for (gi = 0; gi < NCSR; gi++) begin : g_csr
      logic w_rel;
      logic w_inc;
      logic w_dec;

      assign w_rel = wb_wr_csr && (wb_csrno == CSRNOBITS'(gi));
      assign w_inc = w_issue && csr_wr && (csr_rs == CSRNOBITS'(gi));
      assign w_dec = w_rel && (r_csr_cnt[gi] != '0);

      assign w_csr_eff[gi]    = (BYPASS && w_dec) ? r_csr_cnt[gi] - 1'b1 : r_csr_cnt[gi];
      assign csr_busy_vec[gi] = (r_csr_cnt[gi] != '0);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_csr_cnt[gi] <= '0;
        end else if (w_inc && !w_dec) begin
          r_csr_cnt[gi] <= r_csr_cnt[gi] + 1'b1;
        end else if (w_dec && !w_inc) begin
          r_csr_cnt[gi] <= r_csr_cnt[gi] - 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    w_hazard = 1'b0;
    if (rs1_used && (w_gpr_eff[rs1] != '0))                      w_hazard = 1'b1;
    if (rs2_used && (w_gpr_eff[rs2] != '0))                      w_hazard = 1'b1;
    if (csr_rd_used && (w_csr_eff[csr_rs] != '0))               w_hazard = 1'b1;
    if (rd_wr && (rd != '0) && (w_gpr_eff[rd] == CNT_FULL))     w_hazard = 1'b1;
    if (csr_wr && (w_csr_eff[csr_rs] == CNT_FULL))              w_hazard = 1'b1;
  end

  // Flush squashes the DE instruction: neither stall nor issue in that cycle.
  assign w_stall = reset && de_valid && !flush && w_hazard;
  assign w_issue = reset && de_valid && !flush && !w_hazard;

  assign w_gpr_uf = wb_wr_reg && (wb_regno != '0) && (r_gpr_cnt[wb_regno] == '0);
  assign w_csr_uf = wb_wr_csr && (r_csr_cnt[wb_csrno] == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_underflow <= 1'b0;
      r_stall_cycles  <= '0;
    end else begin
      if (w_gpr_uf || w_csr_uf) begin
        r_err_underflow <= 1'b1;
      end
      if (w_stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign stall         = w_stall;
  assign issue         = w_issue;
  assign err_underflow = r_err_underflow;
  assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_de_hazard_scoreboard.sv
// Self-checking bench for de_hazard_scoreboard: a reference model pushes expected
// outputs per cycle to a queue, popped and compared against the DUT mid-cycle.
module tb_de_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        de_valid;
  logic [4:0]  rs1, rs2, rd, wb_regno;
  logic        rs1_used, rs2_used, rd_wr;
  logic [3:0]  csr_rs, wb_csrno;
  logic        csr_rd_used, csr_wr, flush, wb_wr_reg, wb_wr_csr;
  logic        stall, issue, err_underflow;
  logic [31:0] busy_vec, stall_cycles;
  logic [15:0] csr_busy_vec;

  de_hazard_scoreboard dut (
    .clk(clk), .reset(reset), .de_valid(de_valid),
    .rs1(rs1), .rs1_used(rs1_used), .rs2(rs2), .rs2_used(rs2_used),
    .rd(rd), .rd_wr(rd_wr), .csr_rs(csr_rs), .csr_rd_used(csr_rd_used),
    .csr_wr(csr_wr), .flush(flush), .wb_wr_reg(wb_wr_reg), .wb_regno(wb_regno),
    .wb_wr_csr(wb_wr_csr), .wb_csrno(wb_csrno), .stall(stall), .issue(issue),
    .busy_vec(busy_vec), .csr_busy_vec(csr_busy_vec),
    .err_underflow(err_underflow), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        issue;
    logic [31:0] busy;
    logic [15:0] cbusy;
    logic        err;
    logic [31:0] scyc;
  } exp_t;

  exp_t exp_q[$];
  int   m_gpr [32];
  int   m_csr [16];
  logic m_err;
  int   m_scyc;
  int   n_vec;
  int   n_miss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_g(input int r);
    if (r == 0) return 0;
    if (wb_wr_reg && int'(wb_regno) == r && m_gpr[r] > 0) return m_gpr[r] - 1;
    return m_gpr[r];
  endfunction

  function automatic int eff_c(input int r);
    if (wb_wr_csr && int'(wb_csrno) == r && m_csr[r] > 0) return m_csr[r] - 1;
    return m_csr[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 0;
    for (int i = 0; i < 16; i++) m_csr[i] = 0;
    m_err  = 1'b0;
    m_scyc = 0;
  endtask

  task automatic idle();
    de_valid = 0; rs1 = 0; rs1_used = 0; rs2 = 0; rs2_used = 0;
    rd = 0; rd_wr = 0; csr_rs = 0; csr_rd_used = 0; csr_wr = 0; flush = 0;
    wb_wr_reg = 0; wb_regno = 0; wb_wr_csr = 0; wb_csrno = 0;
  endtask

  // Inputs are already driven (just after posedge); predict, compare, advance.
  task automatic cycle(input string tag);
    exp_t e;
    exp_t g;
    logic hz;
    int   wr, wc;
    logic dg, dc;
    hz = (rs1_used && eff_g(int'(rs1)) != 0) ||
         (rs2_used && eff_g(int'(rs2)) != 0) ||
         (csr_rd_used && eff_c(int'(csr_rs)) != 0) ||
         (rd_wr && rd != 0 && eff_g(int'(rd)) == 3) ||
         (csr_wr && eff_c(int'(csr_rs)) == 3);
    e.stall = de_valid && !flush && hz;
    e.issue = de_valid && !flush && !hz;
    for (int i = 0; i < 32; i++) e.busy[i]  = (m_gpr[i] != 0);
    for (int i = 0; i < 16; i++) e.cbusy[i] = (m_csr[i] != 0);
    e.err  = m_err;
    e.scyc = m_scyc;
    exp_q.push_back(e);
    #2;
    g = exp_q.pop_front();
    chk({tag, ".stall"}, 32'(stall), 32'(g.stall));
    chk({tag, ".issue"}, 32'(issue), 32'(g.issue));
    chk({tag, ".busy"},  busy_vec, g.busy);
    chk({tag, ".cbusy"}, 32'(csr_busy_vec), 32'(g.cbusy));
    chk({tag, ".err"},   32'(err_underflow), 32'(g.err));
    chk({tag, ".scyc"},  stall_cycles, g.scyc);
    wr = int'(wb_regno);
    wc = int'(wb_csrno);
    dg = wb_wr_reg && wr != 0 && m_gpr[wr] > 0;
    dc = wb_wr_csr && m_csr[wc] > 0;
    if (wb_wr_reg && wr != 0 && m_gpr[wr] == 0) m_err = 1'b1;
    if (wb_wr_csr && m_csr[wc] == 0) m_err = 1'b1;
    if (dg) m_gpr[wr]--;
    if (dc) m_csr[wc]--;
    if (g.issue && rd_wr && rd != 0) m_gpr[int'(rd)]++;
    if (g.issue && csr_wr) m_csr[int'(csr_rs)]++;
    if (g.stall) m_scyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_gpr(input logic [4:0] r, input string tag);
    idle(); de_valid = 1; rd = r; rd_wr = 1; cycle(tag);
  endtask

  task automatic rel_gpr(input logic [4:0] r, input string tag);
    idle(); wb_wr_reg = 1; wb_regno = r; cycle(tag);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    model_reset();
    idle();
    reset = 1'b0;
    de_valid = 1; rs1 = 5; rs1_used = 1; rd = 5; rd_wr = 1;
    #2;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.issue", 32'(issue), 32'd0);
    chk("rst.busy",  busy_vec, 32'd0);
    chk("rst.scyc",  stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // RAW hazard on x5 with same-cycle WB bypass
    wr_gpr(5, "t1.wr");
    idle(); de_valid = 1; rs1 = 5; rs1_used = 1; cycle("t1.raw");
    cycle("t1.raw2");
    wb_wr_reg = 1; wb_regno = 5; cycle("t1.byp");

    // MAX_PEND writers on x7
    for (int k = 0; k < 3; k++) wr_gpr(7, "t2.wr");
    wr_gpr(7, "t2.full");
    idle(); de_valid = 1; rd = 7; rd_wr = 1; wb_wr_reg = 1; wb_regno = 7; cycle("t2.rel");
    wr_gpr(7, "t2.still_full");
    for (int k = 0; k < 3; k++) rel_gpr(7, "t2.drain");

    // rs2 hazard
    wr_gpr(20, "t2b.wr");
    idle(); de_valid = 1; rs2 = 20; rs2_used = 1; cycle("t2b.rs2");
    rel_gpr(20, "t2b.rel");

    // Same-cycle inc and dec on x9
    wr_gpr(9, "t3.wr");
    idle(); de_valid = 1; rd = 9; rd_wr = 1; wb_wr_reg = 1; wb_regno = 9; cycle("t3.both");
    idle(); cycle("t3.hold");
    rel_gpr(9, "t3.rel");

    // x0 never busy, release of x0 is harmless
    for (int k = 0; k < 5; k++) wr_gpr(0, "t4.x0");
    idle(); de_valid = 1; rs1 = 0; rs1_used = 1; rs2 = 0; rs2_used = 1; cycle("t4.rd0");
    rel_gpr(0, "t4.wb0");

    // CSR write/read hazard and CSR MAX_PEND
    idle(); de_valid = 1; csr_rs = 2; csr_wr = 1; cycle("tc.wr");
    idle(); de_valid = 1; csr_rs = 2; csr_rd_used = 1; cycle("tc.raw");
    wb_wr_csr = 1; wb_csrno = 2; cycle("tc.byp");
    for (int k = 0; k < 4; k++) begin
      idle(); de_valid = 1; csr_rs = 6; csr_wr = 1; cycle("tc.full");
    end
    for (int k = 0; k < 3; k++) begin
      idle(); wb_wr_csr = 1; wb_csrno = 6; cycle("tc.drain");
    end

    // Flush suppresses stall, issue and increments
    wr_gpr(11, "t6.wr");
    idle(); de_valid = 1; rs1 = 11; rs1_used = 1; flush = 1; cycle("t6.flush");
    idle(); de_valid = 1; rd = 12; rd_wr = 1; flush = 1; cycle("t6.noinc");
    idle(); de_valid = 1; rs1 = 11; rs1_used = 1; cycle("t6.stall");
    idle(); de_valid = 1; rs1 = 11; rs1_used = 1; flush = 1; wb_wr_reg = 1; wb_regno = 11; cycle("t6.flrel");
    idle(); cycle("t6.after");

    // Randomised traffic on a few registers
    for (int k = 0; k < 300; k++) begin
      idle();
      de_valid    = 1'($urandom_range(0, 3) != 0);
      rs1         = 5'($urandom_range(0, 3));
      rs1_used    = 1'($urandom_range(0, 1));
      rs2         = 5'($urandom_range(0, 3));
      rs2_used    = 1'($urandom_range(0, 1));
      rd          = 5'($urandom_range(0, 3));
      rd_wr       = 1'($urandom_range(0, 1));
      csr_rs      = 4'($urandom_range(0, 1));
      csr_rd_used = 1'($urandom_range(0, 3) == 0);
      csr_wr      = 1'($urandom_range(0, 3) == 0);
      flush       = 1'($urandom_range(0, 7) == 0);
      wb_wr_reg   = 1'($urandom_range(0, 1));
      wb_regno    = 5'($urandom_range(1, 3));
      wb_wr_csr   = 1'($urandom_range(0, 3) == 0);
      wb_csrno    = 4'($urandom_range(0, 1));
      cycle("rnd");
    end

    // Underflow is sticky until reset
    reset = 1'b0;
    model_reset();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    wr_gpr(14, "t5.wr");
    rel_gpr(3, "t5.uf");
    for (int k = 0; k < 10; k++) begin
      idle(); cycle("t5.idle");
    end
    idle(); de_valid = 1; rs1 = 14; rs1_used = 1;
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t5.rst.err",   32'(err_underflow), 32'd0);
    chk("t5.rst.busy",  busy_vec, 32'd0);
    chk("t5.rst.stall", 32'(stall), 32'd0);
    chk("t5.rst.scyc",  stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(); de_valid = 1; rs1 = 14; rs1_used = 1; cycle("t5.post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
